control_contador: RTL

Sequencing controller for the 8-bit up-counter (`contador_8bits`: `enable`, `reset`, `clk`, `count`, `tc`). It drives the counter's `enable`/`reset` and watches `count` to turn the free-running counter into a programmable interval timer. It supports one-shot and periodic modes, pause, abort and a bounded repeat count. It sits between the control logic that requests timed intervals and a single counter instance.

---
 rtl/control_contador_pkg.sv | 14 +
 rtl/control_contador.sv | 92 +++++++++
 2 files changed

// File: rtl/control_contador_pkg.sv
// Shared types and default widths for the interval-timer sequencer that drives
// an external up-counter.
package control_contador_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultRepW  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_t;

endpackage

// File: rtl/control_contador.sv
// Turns a free-running up-counter into a programmable interval timer with
// one-shot / periodic modes, pause, abort and a bounded repeat count.
module control_contador
    import control_contador_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned REP_W = DefaultRepW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             periodic,
    input  logic [WIDTH-1:0] limit,
    input  logic [REP_W-1:0] reps,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             cnt_enable,
    output logic             cnt_reset,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [REP_W-1:0] periods
);

    state_t           state_q;
    logic [WIDTH-1:0] limit_q;
    logic [REP_W-1:0] reps_q;
    logic [REP_W-1:0] periods_q;
    logic             periodic_q;

    logic             in_run;
    logic             in_fin;
    logic             fin_run;
    logic [REP_W-1:0] periods_inc;

    always_comb begin
        in_run      = (state_q == StRun);
        in_fin      = (state_q == StFin);
        periods_inc = periods_q + REP_W'(1);
        tick        = in_run & ~pause & ~abort & (cnt_count == limit_q);
        // reps_q == 0 means unbounded; the final period is the one that brings
        // the completed count up to reps_q.
        fin_run     = tick & (~periodic_q | ((reps_q != '0) & (periods_inc == reps_q)));
        busy        = in_run;
        cnt_enable  = in_run & ~pause;
        // Counter is held at zero outside RUN and restarted after each period.
        cnt_reset   = ~in_run | tick | abort;
        done        = in_fin & ~abort;
    end

    assign periods = periods_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            limit_q    <= '0;
            reps_q     <= '0;
            periodic_q <= 1'b0;
            periods_q  <= '0;
        end else if (abort) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        limit_q    <= limit;
                        reps_q     <= reps;
                        periodic_q <= periodic;
                        periods_q  <= '0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    if (tick) begin
                        periods_q <= periods_inc;
                    end
                    if (fin_run) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
